// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if -- request/result bundle between the EXE stage and the
// HI/LO multiply/divide unit.
//   master (EXE stage) drives: start, op, val1, val2, mthi, mtlo, mt_data
//   slave  (unit)      drives: busy, done, HI, LO
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

interface hilo_muldiv_unit_if #(
  parameter int WIDTH = `WORD_LEN
);
  logic             start;
  logic [1:0]       op;       // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  logic [WIDTH-1:0] val1;     // multiplicand / dividend
  logic [WIDTH-1:0] val2;     // multiplier / divisor
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, val1, val2, mthi, mtlo, mt_data,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, op, val1, val2, mthi, mtlo, mt_data,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit -- iterative MULT/MULTU/DIV/DIVU unit owning the
// architectural HI/LO pair, plus MTHI/MTLO writes.
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : hilo_muldiv_unit_if.slave (start/op/val1/val2/mthi/mtlo/mt_data
//            in; busy/done/HI/LO out)
// Sequence: IDLE -> CALC (WIDTH cycles, one bit per cycle) -> FIX -> IDLE.
// Signed ops run on magnitudes; FIX restores signs and writes {HI,LO}.
// Optional macro FAST_MULT_EN: MULT/MULTU finish at the start edge with a
// combinational product (busy stays low, done pulses next cycle).
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module hilo_muldiv_unit #(
  parameter int               WIDTH  = `WORD_LEN,
  parameter logic [WIDTH-1:0] DBZ_LO = {WIDTH{1'b1}}
) (
  input logic               clock,
  input logic               reset,
  hilo_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  // mult: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0]   r_opa;
  // mult: {partial product, remaining multiplier bits}
  // div : low half holds dividend bits shifting out / quotient bits shifting in
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_raw1;   // val1 as latched, returned in HI on divide-by-zero
  logic               r_is_div;
  logic               r_neg_q;  // product / quotient must be negated
  logic               r_neg_r;  // remainder must be negated (dividend was negative)

  // ---- operand preparation at the start edge ----
  logic             w_signed, w_neg1, w_neg2;
  logic [WIDTH-1:0] w_abs1, w_abs2;

  assign w_signed = ~bus.op[0];
  assign w_neg1   = w_signed & bus.val1[WIDTH-1];
  assign w_neg2   = w_signed & bus.val2[WIDTH-1];
  assign w_abs1   = w_neg1 ? -bus.val1 : bus.val1;
  assign w_abs2   = w_neg2 ? -bus.val2 : bus.val2;

  // ---- shift-add multiply step ----
  // Add the multiplicand into the upper half when the current multiplier bit
  // is set, then shift the whole accumulator right (carry enters at the top).
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mult_next;

  assign w_madd      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : '0);
  assign w_mult_next = {w_madd, r_acc[WIDTH-1:1]};

  // ---- restoring divide step ----
  // The shifted remainder needs WIDTH+1 bits. If its top bit is set it is
  // certainly >= divisor; otherwise the borrow of the WIDTH+1-bit subtract
  // tells whether the divisor fits.
  logic [WIDTH:0]   w_shrem, w_rem_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

  assign w_shrem    = {r_rem, r_acc[WIDTH-1]};
  assign w_rem_sub  = w_shrem - {1'b0, r_opa};
  assign w_ge       = w_shrem[WIDTH] | ~w_rem_sub[WIDTH];
  assign w_rem_next = w_ge ? w_rem_sub[WIDTH-1:0] : w_shrem[WIDTH-1:0];

  // ---- sign fix-up ----
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot, w_remd;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_remd = r_neg_r ? -r_rem : r_rem;

`ifdef FAST_MULT_EN
  // Sign/zero-extend to 2W bits; the low 2W bits of the product are then
  // correct for both signed and unsigned operands.
  logic [2*WIDTH-1:0] w_ext1, w_ext2, w_fprod;

  assign w_ext1  = {{WIDTH{w_neg1}}, bus.val1};
  assign w_ext2  = {{WIDTH{w_neg2}}, bus.val2};
  assign w_fprod = w_ext1 * w_ext2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opa    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_raw1   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // a start on the same edge as MTHI/MTLO wins; the MT write is dropped
`ifdef FAST_MULT_EN
            if (!bus.op[1]) begin
              r_hi   <= w_fprod[2*WIDTH-1:WIDTH];
              r_lo   <= w_fprod[WIDTH-1:0];
              r_done <= 1'b1;
            end else
`endif
            begin
              r_state  <= S_CALC;
              r_busy   <= 1'b1;
              r_count  <= '0;
              r_opa    <= bus.op[1] ? w_abs2 : w_abs1;
              r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs1 : w_abs2)};
              r_rem    <= '0;
              r_raw1   <= bus.val1;
              r_is_div <= bus.op[1];
              r_neg_q  <= w_neg1 ^ w_neg2;
              r_neg_r  <= w_neg1;
            end
          end else begin
            if (bus.mthi) r_hi <= bus.mt_data;
            if (bus.mtlo) r_lo <= bus.mt_data;
          end
        end

        S_CALC: begin
          if (r_is_div) begin
            r_rem             <= w_rem_next;
            r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_mult_next;
          end
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) r_state <= S_FIX;
        end

        S_FIX: begin
          if (r_is_div) begin
            // zero divisor still runs the full iteration; result is overridden here
            if (r_opa == '0) begin
              r_hi <= r_raw1;
              r_lo <= DBZ_LO;
            end else begin
              r_hi <= w_remd;
              r_lo <= w_quot;
            end
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit (WIDTH=32). A reference model built on plain
// 64-bit arithmetic tracks HI/LO/busy/done; one compare process checks the
// DUT against it every cycle. Directed cases pin hand-computed values.
module tb_hilo_muldiv_unit;
`ifdef FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int LAT = 33;  // busy cycles for an iterative op

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(32)) ifc ();
  hilo_muldiv_unit #(.WIDTH(32)) dut (.clock(clk), .reset(rst), .bus(ifc));

  int vec  = 0;
  int miss = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     p;
    hi = '0; lo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = ua * ub;      hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin hi = 32'h0; lo = 32'h80000000; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  bit          m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
      end else if (ifc.start) begin
        ref_op(ifc.op, ifc.val1, ifc.val2, p_hi, p_lo);
        if (FAST && !ifc.op[1]) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
        else m_left = LAT;
      end else begin
        if (ifc.mthi) m_hi = ifc.mt_data;
        if (ifc.mtlo) m_lo = ifc.mt_data;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      vec++;
      if (ifc.busy !== (m_left > 0) || ifc.done !== m_done || ifc.HI !== m_hi || ifc.LO !== m_lo) begin
        miss++;
        $display("FAIL cycle t=%0t: busy=%b done=%b HI=%h LO=%h, model busy=%b done=%b HI=%h LO=%h",
                 $time, ifc.busy, ifc.done, ifc.HI, ifc.LO, (m_left > 0), m_done, m_hi, m_lo);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    ifc.start = 1'b1; ifc.op = op; ifc.val1 = a; ifc.val2 = b;
    ifc.mthi = 1'b0; ifc.mtlo = 1'b0;
    @(posedge clk); #2;
    ifc.start = 1'b0;
  endtask

  task automatic mt(input bit hi, input bit lo, input logic [31:0] d);
    @(posedge clk); #2;
    ifc.mthi = hi; ifc.mtlo = lo; ifc.mt_data = d;
    @(posedge clk); #2;
    ifc.mthi = 1'b0; ifc.mtlo = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int nbusy);
    bit seen = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (ifc.busy) nbusy++;
      if (ifc.done) seen = 1'b1;
    end
    vec++;
    if (!seen) begin
      miss++;
      $display("FAIL %s: done not seen within 80 cycles", nm);
    end
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      4:       return 32'h0 - 32'($urandom_range(1, 15));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          nb;
    logic [31:0] h, l;
    ifc.start = 1'b0; ifc.op = 2'b00; ifc.val1 = '0; ifc.val2 = '0;
    ifc.mthi = 1'b0; ifc.mtlo = 1'b0; ifc.mt_data = '0;

    // model pins against hand arithmetic
    ref_op(2'b10, 32'hFFFFFFF9, 32'd2, h, l);
    chk("model DIV -7/2 LO", l, 32'hFFFFFFFD);
    chk("model DIV -7/2 HI", h, 32'hFFFFFFFF);
    ref_op(2'b00, 32'hFFFFFFFE, 32'd3, h, l);
    chk("model MULT -2*3 HI", h, 32'hFFFFFFFF);
    chk("model MULT -2*3 LO", l, 32'hFFFFFFFA);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset busy", {31'b0, ifc.busy}, 32'd0);
    chk("reset HI", ifc.HI, 32'h0);
    chk("reset LO", ifc.LO, 32'h0);

    // 1: reset in the middle of a DIVU
    mt(1'b1, 1'b1, 32'hA5A5A5A5);
    go(2'b11, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midop reset busy", {31'b0, ifc.busy}, 32'd0);
    chk("midop reset done", {31'b0, ifc.done}, 32'd0);
    chk("midop reset HI", ifc.HI, 32'h0);
    chk("midop reset LO", ifc.LO, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    go(2'b11, 32'd100, 32'd7);
    wait_done("divu after reset", nb);
    chk("divu after reset HI", ifc.HI, 32'd2);
    chk("divu after reset LO", ifc.LO, 32'd14);

    // 2: MULT -2*3
    go(2'b00, 32'hFFFFFFFE, 32'd3);
    wait_done("mult", nb);
    chk("mult busy cycles", 32'(nb), FAST ? 32'd0 : 32'(LAT));
    chk("mult HI", ifc.HI, 32'hFFFFFFFF);
    chk("mult LO", ifc.LO, 32'hFFFFFFFA);
    @(negedge clk);
    chk("done single pulse", {31'b0, ifc.done}, 32'd0);

    // 3: MULTU max*max
    go(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu", nb);
    chk("multu busy cycles", 32'(nb), FAST ? 32'd0 : 32'(LAT));
    chk("multu HI", ifc.HI, 32'hFFFFFFFE);
    chk("multu LO", ifc.LO, 32'h00000001);

    // 4: signed divide and divide-by-zero
    go(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done("div", nb);
    chk("div LO", ifc.LO, 32'hFFFFFFFD);
    chk("div HI", ifc.HI, 32'hFFFFFFFF);
    go(2'b11, 32'd7, 32'd0);
    wait_done("divu by 0", nb);
    chk("dbz busy cycles", 32'(nb), 32'(LAT));
    chk("dbz HI", ifc.HI, 32'd7);
    chk("dbz LO", ifc.LO, 32'hFFFFFFFF);

    // 5: signed overflow with a start pulsed mid-op
    go(2'b10, 32'h80000000, 32'hFFFFFFFF);
    @(posedge clk); #2;
    ifc.start = 1'b1; ifc.op = 2'b01; ifc.val1 = 32'd5; ifc.val2 = 32'd5;
    @(posedge clk); #2 ifc.start = 1'b0;
    wait_done("div ovf", nb);
    chk("div ovf LO", ifc.LO, 32'h80000000);
    chk("div ovf HI", ifc.HI, 32'h0);

    // 6: MTHI at idle, MTLO while busy
    mt(1'b1, 1'b0, 32'h12345678);
    chk("mthi HI", ifc.HI, 32'h12345678);
    chk("mthi no done", {31'b0, ifc.done}, 32'd0);
    go(2'b11, 32'd12, 32'd4);
    @(posedge clk); #2;
    ifc.mtlo = 1'b1; ifc.mt_data = 32'hDEADBEEF;
    @(posedge clk); #2 ifc.mtlo = 1'b0;
    chk("mtlo while busy LO", ifc.LO, 32'h80000000);
    wait_done("divu 12/4", nb);
    chk("divu 12/4 LO", ifc.LO, 32'd3);
    chk("divu 12/4 HI", ifc.HI, 32'd0);

    // randomized traffic: starts (also while busy), MT writes (also colliding
    // with start), occasional resets; checked every cycle by the model
    for (int c = 0; c < 12000; c++) begin
      @(posedge clk); #2;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 1999) == 0) rst = 1'b1;
      ifc.start   = ($urandom_range(0, 7) == 0);
      ifc.op      = 2'($urandom_range(0, 3));
      ifc.val1    = rval();
      ifc.val2    = rval();
      ifc.mthi    = ($urandom_range(0, 5) == 0);
      ifc.mtlo    = ($urandom_range(0, 5) == 0);
      ifc.mt_data = $urandom();
    end
    @(posedge clk); #2;
    ifc.start = 1'b0; ifc.mthi = 1'b0; ifc.mtlo = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
